// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: start bit, DATA_W data bits LSB first, optional even parity, stop bit.
// Define UART_TX_PARITY_EN to compile in the parity bit (PARITY state).
module uart_tx_ctrl #(
   parameter int CLKS_PER_BIT = 868,
   parameter int DATA_W       = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              tx_start,
   input  logic [DATA_W-1:0] tx_data,
   output logic              tx_ready,
   output logic              tx_busy,
   output logic              tx_done,
   output logic              tx
);

   localparam int BAUD_W = $clog2(CLKS_PER_BIT);
   localparam int BIT_W  = $clog2(DATA_W + 1);
   localparam logic [BAUD_W-1:0] BAUD_TC  = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [BIT_W-1:0]  BIT_LAST = BIT_W'(DATA_W - 1);

`ifdef UART_TX_PARITY_EN
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
   typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

   state_t             state, state_nxt;
   logic [BAUD_W-1:0]  baud_cnt, baud_nxt;
   logic [BIT_W-1:0]   bit_cnt, bit_nxt;
   logic [DATA_W-1:0]  shift_reg, shift_nxt;
   logic               done_nxt;
   logic               tx_nxt;
   logic               baud_tc;
`ifdef UART_TX_PARITY_EN
   logic               par, par_nxt;
`endif

   assign tx_ready = (state == IDLE);
   assign tx_busy  = ~tx_ready;
   assign baud_tc  = (baud_cnt == BAUD_TC);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         baud_cnt  <= '0;
         bit_cnt   <= '0;
         shift_reg <= '0;
         tx_done   <= 1'b0;
         tx        <= 1'b1;
`ifdef UART_TX_PARITY_EN
         par       <= 1'b0;
`endif
      end else begin
         state     <= state_nxt;
         baud_cnt  <= baud_nxt;
         bit_cnt   <= bit_nxt;
         shift_reg <= shift_nxt;
         tx_done   <= done_nxt;
         tx        <= tx_nxt;
`ifdef UART_TX_PARITY_EN
         par       <= par_nxt;
`endif
      end
   end

   always_comb begin
      state_nxt = state;
      baud_nxt  = baud_tc ? '0 : baud_cnt + BAUD_W'(1);
      bit_nxt   = bit_cnt;
      shift_nxt = shift_reg;
      done_nxt  = 1'b0;
`ifdef UART_TX_PARITY_EN
      par_nxt   = par;
`endif
      case (state)
         IDLE: begin
            baud_nxt = '0;
            if (tx_start) begin
               shift_nxt = tx_data;
               bit_nxt   = '0;
               state_nxt = START;
`ifdef UART_TX_PARITY_EN
               par_nxt   = ^tx_data;
`endif
            end
         end
         START: if (baud_tc) state_nxt = DATA;
         DATA: begin
            if (baud_tc) begin
               shift_nxt = shift_reg >> 1;
               bit_nxt   = bit_cnt + BIT_W'(1);
               if (bit_cnt == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
                  state_nxt = PARITY;
`else
                  state_nxt = STOP;
`endif
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         PARITY: if (baud_tc) state_nxt = STOP;
`endif
         STOP: begin
            if (baud_tc) begin
               state_nxt = IDLE;
               done_nxt  = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase

      // tx is derived from the next state so the registered line changes on the same edge as the state
      case (state_nxt)
         START:   tx_nxt = 1'b0;
         DATA:    tx_nxt = shift_nxt[0];
`ifdef UART_TX_PARITY_EN
         PARITY:  tx_nxt = par_nxt;
`endif
         default: tx_nxt = 1'b1;
      endcase
   end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed self-checking bench for uart_tx_ctrl with CLKS_PER_BIT = 4, DATA_W = 8.
module tb_uart_tx_ctrl;

   localparam int CPB = 4;

   logic       clk;
   logic       rst;
   logic       tx_start;
   logic [7:0] tx_data;
   logic       tx_ready, tx_busy, tx_done, tx;

   int total = 0;
   int bad   = 0;

   uart_tx_ctrl #(.CLKS_PER_BIT(CPB), .DATA_W(8)) dut (
      .clk      (clk),
      .rst      (rst),
      .tx_start (tx_start),
      .tx_data  (tx_data),
      .tx_ready (tx_ready),
      .tx_busy  (tx_busy),
      .tx_done  (tx_done),
      .tx       (tx)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Called at a sample point with the DUT idle. mode 1: stray 0x55 start pulse mid-frame;
   // mode 2: scramble tx_data every cycle. hold keeps tx_start high for a back-to-back frame.
   task automatic run_frame(input logic [7:0] d, input logic p, input int mode, input logic hold);
      logic [10:0] bits;
      int          n;
      tx_start = 1'b1;
      tx_data  = d;
      step();
      if (!hold) tx_start = 1'b0;
      bits[0] = 1'b0;
      for (int i = 0; i < 8; i++) bits[1+i] = d[i];
`ifdef UART_TX_PARITY_EN
      bits[9]  = p;
      bits[10] = 1'b1;
      n = 11;
`else
      bits[9]  = 1'b1;
      bits[10] = 1'b1;
      n = 10;
      if (p === 1'bx) n = 10;
`endif
      chk("ready_lo", tx_ready, 0);
      chk("busy_hi", tx_busy, 1);
      for (int i = 0; i < n; i++) begin
         for (int c = 0; c < CPB; c++) begin
            if (mode == 1 && i * CPB + c == 10) begin
               tx_start = 1'b1;
               tx_data  = 8'h55;
            end
            if (mode == 1 && i * CPB + c == 11) tx_start = 1'b0;
            if (mode == 2) tx_data = 8'($urandom);
            chk("tx_bit", tx, bits[i]);
            chk("done_lo", tx_done, 0);
            step();
         end
      end
      chk("done_pulse", tx_done, 1);
      chk("ready_at_done", tx_ready, 1);
      chk("tx_at_done", tx, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst      = 1'b0;
      tx_start = 1'b0;
      tx_data  = 8'h00;
      repeat (3) step();
      chk("rst_tx", tx, 1);
      chk("rst_ready", tx_ready, 1);
      chk("rst_busy", tx_busy, 0);
      chk("rst_done", tx_done, 0);
      rst = 1'b1;
      for (int i = 0; i < 50; i++) begin
         step();
         chk("idle_tx", tx, 1);
         chk("idle_ready", tx_ready, 1);
      end

      // 0xA5: parity 0
      run_frame(8'hA5, 1'b0, 0, 1'b0);
      step();
      chk("done_one_cycle", tx_done, 0);

      // 0x07: parity 1
      run_frame(8'h07, 1'b1, 0, 1'b0);
      step();

      // stray start while busy is neither honoured nor queued
      run_frame(8'hC3, 1'b0, 1, 1'b0);
      for (int i = 0; i < 8; i++) begin
         step();
         chk("no_queue_tx", tx, 1);
         chk("no_queue_ready", tx_ready, 1);
      end

      // back-to-back with tx_start held; stop level spans 5 cycles
      run_frame(8'h0F, 1'b0, 0, 1'b1);
      run_frame(8'hF0, 1'b0, 0, 1'b0);
      step();

      // asynchronous reset during data bit 3 of 0xA5 (bit value 0)
      tx_start = 1'b1;
      tx_data  = 8'hA5;
      step();
      tx_start = 1'b0;
      repeat (17) step();
      chk("pre_abort_tx", tx, 0);
      #2;
      rst = 1'b0;
      #1;
      chk("abort_tx", tx, 1);
      chk("abort_ready", tx_ready, 1);
      chk("abort_done", tx_done, 0);
      repeat (2) step();
      chk("abort_hold_done", tx_done, 0);
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("post_rst_tx", tx, 1);
         chk("post_rst_done", tx_done, 0);
         chk("post_rst_ready", tx_ready, 1);
      end
      run_frame(8'h3C, 1'b0, 0, 1'b0);
      step();

      // tx_data scrambled after acceptance
      run_frame(8'h81, 1'b0, 2, 1'b0);
      step();
      chk("final_idle", tx, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/uart_tx_ctrl.md
# uart_tx_ctrl

UART transmit controller for the multicycle RISC-V SoC's serial port. It accepts one data word per handshake and serializes it on `tx` as start bit, data bits (LSB first), an optional parity bit and a stop bit. It sequences an internal baud-tick counter and an internal bit-index counter. It sits between the memory-mapped UART register block (CPU side) and the pin.

## Interface
- `CLKS_PER_BIT`, 868: clock cycles per serial bit (100 MHz / 115200). Must be ≥ 2.
- `DATA_W`, 8: data bits per frame, 5–9.
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-low reset: `rst` = 0 resets immediately, independent of `clk`.
- `tx_start`  in  1  request to send `tx_data`. Sampled only when `tx_ready` = 1.
- `tx_data`  in  DATA_W  word to transmit. Captured in the accepting cycle.
- `tx_ready`  out  1  high in IDLE only: controller can accept a word.
- `tx_busy`  out  1  inverse of `tx_ready`.
- `tx_done`  out  1  one-cycle pulse when a frame's stop bit completes.
- `tx`  out  1  serial line; idle high. Registered output, glitch-free.

## Operation
- States: IDLE, START, DATA, PARITY (only with macro), STOP.
- IDLE
  - `tx` = 1.
  - `tx_start` = 1: latch `tx_data` into the shift register, clear the baud and bit counters, go to START.
- START
  - `tx` = 0 for CLKS_PER_BIT cycles, then go to DATA.
- DATA
  - `tx` = shift_reg[0].
  - At each baud-counter terminal count (CLKS_PER_BIT−1): shift right and increment the bit counter.
  - After DATA_W bits: go to PARITY if enabled, else STOP.
- PARITY
  - `tx` = parity bit for CLKS_PER_BIT cycles, then go to STOP.
- STOP
  - `tx` = 1 for CLKS_PER_BIT cycles.
  - On the terminal count: assert `tx_done` for the next cycle and go to IDLE.
- Counters
  - Baud counter width is $clog2(CLKS_PER_BIT). It counts 0..CLKS_PER_BIT−1, clears on wrap and on every state change.
  - Bit counter width is $clog2(DATA_W+1). It never wraps within a frame.
- Changes to `tx_data` after acceptance do not affect the frame in flight.
- `tx_start` while busy is ignored and not queued. The requester must hold it until it sees `tx_ready`.
- Reset values: state IDLE, `tx` = 1, `tx_ready` = 1, `tx_busy` = 0, `tx_done` = 0, counters 0, shift register 0.

## Timing
- Acceptance edge: the edge where `tx_start` & `tx_ready` = 1.
- `tx` falls at that same edge (the start bit begins the cycle after `tx_start` is sampled). `tx_ready` falls at that same edge.
- Frame length: (DATA_W + 2 [+1 with parity]) × CLKS_PER_BIT cycles, measured from the `tx` fall to the `tx_done` cycle.
- `tx_done` is high during the first IDLE cycle, concurrently with `tx_ready` = 1.
- A `tx_start` held during the `tx_done` cycle is accepted there. This gives back-to-back frames with a stop bit of CLKS_PER_BIT+1 cycles.
- Reset mid-frame: `tx` returns to 1 immediately (asynchronous). The frame is aborted with no `tx_done`. After reset release, the block is IDLE on the first edge.

## Configuration
- Macro: `UART_TX_PARITY_EN`.
- Defined:
  - PARITY state is compiled in.
  - The parity bit is even parity (XOR of the DATA_W data bits), sent after the last data bit.
  - Frame = 11 bits for DATA_W = 8.
- Undefined:
  - No PARITY state or logic; DATA goes directly to STOP.
  - Frame = DATA_W + 2 bits (8N1 for the defaults).

## Test plan
- Reset, then idle (CLKS_PER_BIT = 4, DATA_W = 8).
  - Hold `rst` = 0 for 3 cycles, then release.
  - Required: `tx` = 1, `tx_ready` = 1, `tx_done` = 0. `tx` stays 1 for 50 cycles with `tx_start` = 0.
- Single frame, no parity.
  - Stimulus: `tx_data` = 0xA5, one-cycle `tx_start`.
  - Required on `tx`, each level held 4 cycles: 0, 1,0,1,0,0,1,0,1, 1.
  - Required: `tx_done` pulses exactly 40 cycles after the `tx` fall.
- Parity, with `UART_TX_PARITY_EN` defined.
  - 0xA5: parity bit 0, frame 44 cycles.
  - 0x07: parity bit 1.
- Busy and back-to-back.
  - Pulse `tx_start` with 0x55 while busy mid-frame: it is ignored, and the frame in flight is unchanged.
  - Hold `tx_start` high with 0x0F then 0xF0 (data switched in the `tx_done` cycle).
  - Required: two frames, with a stop level of 5 cycles between them.
- Reset mid-frame.
  - Stimulus: assert `rst` = 0 asynchronously, between clock edges, during DATA bit 3.
  - Required: `tx` = 1 and `tx_ready` = 1 immediately, with no `tx_done`.
  - Required: the next `tx_start` of 0x3C produces a correct full frame.
- Data stability.
  - Stimulus: change `tx_data` every cycle after acceptance of 0x81.
  - Required: the serialized bits match 0x81.
